// File: rtl/dft4_network.sv
// 4-point DFT on complex {re,im} words: two registered radix-2 butterfly stages.
// Twiddles are only +-1 and +-j, so the datapath is adders and subtractors only.
module dft4_network #(
  parameter int WORD_SZ = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [WORD_SZ-1:0] i_A,
  input  logic [WORD_SZ-1:0] i_B,
  input  logic [WORD_SZ-1:0] i_C,
  input  logic [WORD_SZ-1:0] i_D,
  output logic               o_valid,
  output logic [WORD_SZ-1:0] o_net_A,
  output logic [WORD_SZ-1:0] o_net_B,
  output logic [WORD_SZ-1:0] o_net_C,
  output logic [WORD_SZ-1:0] o_net_D
);

  localparam int HALF_WORD = WORD_SZ / 2;
  localparam int GUARD_W   = HALF_WORD + 1;

  typedef logic signed [GUARD_W-1:0] guard_t;
  typedef struct packed {
    guard_t re;
    guard_t im;
  } wide_cplx_t;

  function automatic guard_t widen(input logic [HALF_WORD-1:0] x);
    return {x[HALF_WORD-1], x};
  endfunction

  function automatic guard_t re_of(input logic [WORD_SZ-1:0] w);
    return widen(w[WORD_SZ-1:HALF_WORD]);
  endfunction

  function automatic guard_t im_of(input logic [WORD_SZ-1:0] w);
    return widen(w[HALF_WORD-1:0]);
  endfunction

  // Outputs wrap modulo 2^HALF_WORD, so dropping the guard bit is exact.
  function automatic logic [HALF_WORD-1:0] narrow(input guard_t x);
    return x[HALF_WORD-1:0];
  endfunction

  wide_cplx_t s0, s1, s2, s3;
  logic       valid_s1;

  // Stage 1: s0=A+C, s1=A-C, s2=B+D, s3=B-D, one guard bit so no overflow here.
  // NOTE: registers use non-blocking assignments so every stage samples the
  // previous stage's old value on the same edge; blocking would collapse the pipe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: every pipeline register, data included, is cleared so the
      // outputs read zero during and right after reset.
      s0       <= '0;
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      valid_s1 <= 1'b0;
    end else begin
      s0.re    <= re_of(i_A) + re_of(i_C);
      s0.im    <= im_of(i_A) + im_of(i_C);
      s1.re    <= re_of(i_A) - re_of(i_C);
      s1.im    <= im_of(i_A) - im_of(i_C);
      s2.re    <= re_of(i_B) + re_of(i_D);
      s2.im    <= im_of(i_B) + im_of(i_D);
      s3.re    <= re_of(i_B) - re_of(i_D);
      s3.im    <= im_of(i_B) - im_of(i_D);
      valid_s1 <= i_valid;
    end
  end

  // Stage 2: X1 = s1 - j*s3, X3 = s1 + j*s3; multiplying by j swaps re/im.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_net_A <= '0;
      o_net_B <= '0;
      o_net_C <= '0;
      o_net_D <= '0;
      o_valid <= 1'b0;
    end else begin
      o_net_A <= {narrow(s0.re + s2.re), narrow(s0.im + s2.im)};
      o_net_B <= {narrow(s1.re + s3.im), narrow(s1.im - s3.re)};
      o_net_C <= {narrow(s0.re - s2.re), narrow(s0.im - s2.im)};
      o_net_D <= {narrow(s1.re - s3.im), narrow(s1.im + s3.re)};
      o_valid <= valid_s1;
    end
  end

endmodule

// File: tb/tb_dft4_network.sv
// Directed bench for dft4_network: reset, DC, impulses, wrap-around, streaming
// with valid gaps against a direct-DFT model, and asynchronous mid-stream reset.
module tb_dft4_network;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] a, b, c, d;
  logic        o_valid;
  logic [15:0] o_a, o_b, o_c, o_d;

  int vectors     = 0;
  int miscompares = 0;

  dft4_network #(.WORD_SZ(16)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .i_A     (a),
    .i_B     (b),
    .i_C     (c),
    .i_D     (d),
    .o_valid (o_valid),
    .o_net_A (o_a),
    .o_net_B (o_b),
    .o_net_C (o_c),
    .o_net_D (o_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] xa, input logic [15:0] xb,
                       input logic [15:0] xc, input logic [15:0] xd, input logic v);
    a = xa; b = xb; c = xc; d = xd; valid = v;
  endtask

  task automatic check_bins(input string tag, input logic [63:0] exp);
    check({tag, "_valid"}, {15'd0, o_valid}, 16'd1);
    check({tag, "_X0"}, o_a, exp[63:48]);
    check({tag, "_X1"}, o_b, exp[47:32]);
    check({tag, "_X2"}, o_c, exp[31:16]);
    check({tag, "_X3"}, o_d, exp[15:0]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {15'd0, o_valid}, 16'd0);
    check({tag, "_A"}, o_a, 16'h0000);
    check({tag, "_B"}, o_b, 16'h0000);
    check({tag, "_C"}, o_c, 16'h0000);
    check({tag, "_D"}, o_d, 16'h0000);
  endtask

  // Direct DFT: X_k = sum x_n * (-j)^(n*k), each component wrapped to 8 bits.
  function automatic logic [63:0] model(input logic [15:0] xa, input logic [15:0] xb,
                                        input logic [15:0] xc, input logic [15:0] xd);
    int ar, ai, br, bi, cr, ci, dr, di;
    logic [7:0] r0, i0, r1, i1, r2, i2, r3, i3;
    ar = int'($signed(xa[15:8])); ai = int'($signed(xa[7:0]));
    br = int'($signed(xb[15:8])); bi = int'($signed(xb[7:0]));
    cr = int'($signed(xc[15:8])); ci = int'($signed(xc[7:0]));
    dr = int'($signed(xd[15:8])); di = int'($signed(xd[7:0]));
    r0 = 8'(ar + br + cr + dr);  i0 = 8'(ai + bi + ci + di);
    r1 = 8'(ar + bi - cr - di);  i1 = 8'(ai - br - ci + dr);
    r2 = 8'(ar - br + cr - dr);  i2 = 8'(ai - bi + ci - di);
    r3 = 8'(ar - bi - cr + di);  i3 = 8'(ai + br - ci - dr);
    return {r0, i0, r1, i1, r2, i2, r3, i3};
  endfunction

  // One isolated frame: bins 2 clocks later, then o_valid must drop again.
  task automatic run_frame(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                           input logic [15:0] xc, input logic [15:0] xd, input logic [63:0] exp);
    drive(xa, xb, xc, xd, 1'b1);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    check_bins(tag, exp);
    @(negedge clk);
    check({tag, "_gap"}, {15'd0, o_valid}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_f [10];
    logic        exp_v [10];
    logic        pat   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] fa, fb, fc, fd;

    // Reset held with a valid frame on the inputs: outputs must stay zero.
    rst = 1'b1;
    drive(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b1);
    repeat (3) @(negedge clk);
    check_zero("reset");
    drive(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Hand-computed directed frames.
    run_frame("dc", 16'h0100, 16'h0100, 16'h0100, 16'h0100,
              {16'h0400, 16'h0000, 16'h0000, 16'h0000});
    run_frame("imp_a", 16'h0100, 16'h0000, 16'h0000, 16'h0000,
              {16'h0100, 16'h0100, 16'h0100, 16'h0100});
    run_frame("imp_b", 16'h0000, 16'h0100, 16'h0000, 16'h0000,
              {16'h0100, 16'h00FF, 16'hFF00, 16'h0001});
    run_frame("wrap64", 16'h4000, 16'h4000, 16'h4000, 16'h4000,
              {16'h0000, 16'h0000, 16'h0000, 16'h0000});
    run_frame("wrap127", 16'h7F7F, 16'h0101, 16'h0101, 16'h0101,
              {16'h8282, 16'h7E7E, 16'h7E7E, 16'h7E7E});

    // Streaming: 4 back-to-back frames, then gaps; o_valid tracks i_valid by 2.
    for (int t = 0; t < 10; t++) begin
      if (t >= 2) begin
        check($sformatf("stream%0d_valid", t - 2), {15'd0, o_valid}, {15'd0, exp_v[t-2]});
        if (exp_v[t-2]) check_bins($sformatf("stream%0d", t - 2), exp_f[t-2]);
      end
      if (t < 8) begin
        fa = 16'($urandom); fb = 16'($urandom); fc = 16'($urandom); fd = 16'($urandom);
        exp_v[t] = pat[t];
        exp_f[t] = model(fa, fb, fc, fd);
        drive(fa, fb, fc, fd, pat[t]);
      end else begin
        drive(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      end
      @(negedge clk);
    end

    // Asynchronous reset between edges with frames in flight.
    drive(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1);
    @(negedge clk);
    drive(16'h0505, 16'h0A0A, 16'hF0F0, 16'h0F0F, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    check_zero("rst_hold");
    drive(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_stale1", {15'd0, o_valid}, 16'd0);
    @(negedge clk);
    check("post_rst_stale2", {15'd0, o_valid}, 16'd0);

    // First valid frame after release appears exactly 2 clocks later.
    drive(16'h0302, 16'hFF01, 16'h0000, 16'h02FE, 1'b1);
    @(negedge clk);
    valid = 1'b0;
    check("post_rst_lat1", {15'd0, o_valid}, 16'd0);
    @(negedge clk);
    check_bins("post_rst", model(16'h0302, 16'hFF01, 16'h0000, 16'h02FE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
